router_out_arb: RTL

Packet-atomic round-robin scheduler that shares one downstream byte link between the router's three output FIFOs. It sits after FIFOs 0/1/2, pops one complete packet at a time from the granted FIFO, and presents it on a single registered valid/ready output. It also checks each packet's parity on the fly.

---
 rtl/router_out_arb_if.sv | 38 +++
 rtl/router_out_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/router_out_arb_if.sv
// Bus bundle for router_out_arb: the three FIFO read ports on one side and the
// downstream valid/ready byte link plus status on the other.
`timescale 1ns/1ps
interface router_out_arb_if;
  localparam int unsigned DW = 8;
  localparam int unsigned GW = 2;

  logic          fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic [DW-1:0] fifo_dout_0, fifo_dout_1, fifo_dout_2;
  logic          read_enb_0, read_enb_1, read_enb_2;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [GW-1:0] grant;
  logic          busy;
  logic          parity_err;
  logic          soft_reset_0, soft_reset_1, soft_reset_2;

  // Arbiter side
  modport slave (
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  fifo_dout_0, fifo_dout_1, fifo_dout_2,
    input  out_ready,
    output read_enb_0, read_enb_1, read_enb_2,
    output out_data, out_valid, grant, busy, parity_err,
    output soft_reset_0, soft_reset_1, soft_reset_2
  );

  // FIFO / downstream side
  modport master (
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output fifo_dout_0, fifo_dout_1, fifo_dout_2,
    output out_ready,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  out_data, out_valid, grant, busy, parity_err,
    input  soft_reset_0, soft_reset_1, soft_reset_2
  );
endinterface

// File: rtl/router_out_arb.sv
// Packet-atomic round-robin scheduler of three output FIFOs onto one byte link,
// with on-the-fly packet parity check. Optional stall watchdog: ROUTER_ARB_WDOG_EN.
`timescale 1ns/1ps
module router_out_arb #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             resetn,
  router_out_arb_if.slave  bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 7;
  localparam int unsigned GW = 2;
  localparam logic [GW-1:0] NO_GRANT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2
  } state_t;

  if (TIMEOUT == 0) begin : g_timeout_check
    $error("router_out_arb: TIMEOUT must be nonzero");
  end

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] xor_q, xor_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          parity_err_q, parity_err_d;

  logic [2:0]    empty_vec;
  logic          head_empty;
  logic [DW-1:0] head_byte;
  logic          can_pop;
  logic [GW-1:0] pick, cand;
  logic          pick_ok;

`ifdef ROUTER_ARB_WDOG_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic [2:0]    soft_reset_q, soft_reset_d;
`endif

  // Head-of-line view of the currently granted FIFO
  always_comb begin
    empty_vec  = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    head_empty = 1'b1;
    head_byte  = '0;
    case (grant_q)
      2'd0: begin head_empty = bus.fifo_empty_0; head_byte = bus.fifo_dout_0; end
      2'd1: begin head_empty = bus.fifo_empty_1; head_byte = bus.fifo_dout_1; end
      2'd2: begin head_empty = bus.fifo_empty_2; head_byte = bus.fifo_dout_2; end
      default: ;
    endcase
    can_pop = ((state_q == S_HEAD) || (state_q == S_BODY)) && !head_empty &&
              (!out_valid_q || bus.out_ready);
  end

  // Round-robin pick: last+1, last+2, then last itself
  always_comb begin
    pick    = NO_GRANT;
    pick_ok = 1'b0;
    cand    = '0;
    for (int k = 1; k <= 3; k++) begin
      cand = GW'((int'(last_q) + k) % 3);
      if (!pick_ok && !empty_vec[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    xor_d        = xor_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    parity_err_d = 1'b0;
`ifdef ROUTER_ARB_WDOG_EN
    stall_d      = stall_q;
    soft_reset_d = '0;
`endif

    if (can_pop) begin
      out_data_d  = head_byte;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          grant_d = pick;
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        if (can_pop) begin
          cnt_d   = CW'(head_byte[7:2]) + CW'(1);
          xor_d   = head_byte;
          state_d = S_BODY;
        end
      end
      S_BODY: begin
        if (can_pop) begin
          xor_d = xor_q ^ head_byte;
          cnt_d = cnt_q - CW'(1);
          // cnt==1 means this pop is the parity byte
          if (cnt_q == CW'(1)) begin
            parity_err_d = ((xor_q ^ head_byte) != '0);
            last_d       = grant_q;
            grant_d      = NO_GRANT;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef ROUTER_ARB_WDOG_EN
    // Stall watchdog: abort the granted FIFO after TIMEOUT cycles without a pop
    if ((state_q == S_IDLE) || can_pop) begin
      stall_d = '0;
    end else begin
      stall_d = stall_q + SW'(1);
      if (stall_d == SW'(TIMEOUT)) begin
        soft_reset_d[grant_q] = 1'b1;
        out_valid_d           = 1'b0;
        last_d                = grant_q;
        grant_d               = NO_GRANT;
        state_d               = S_IDLE;
        stall_d               = '0;
      end
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      grant_q      <= NO_GRANT;
      last_q       <= 2'd2;
      cnt_q        <= '0;
      xor_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef ROUTER_ARB_WDOG_EN
      stall_q      <= '0;
      soft_reset_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      xor_q        <= xor_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      parity_err_q <= parity_err_d;
`ifdef ROUTER_ARB_WDOG_EN
      stall_q      <= stall_d;
      soft_reset_q <= soft_reset_d;
`endif
    end
  end

  assign bus.read_enb_0 = can_pop && (grant_q == 2'd0);
  assign bus.read_enb_1 = can_pop && (grant_q == 2'd1);
  assign bus.read_enb_2 = can_pop && (grant_q == 2'd2);
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.parity_err = parity_err_q;

`ifdef ROUTER_ARB_WDOG_EN
  assign bus.soft_reset_0 = soft_reset_q[0];
  assign bus.soft_reset_1 = soft_reset_q[1];
  assign bus.soft_reset_2 = soft_reset_q[2];
`else
  assign bus.soft_reset_0 = 1'b0;
  assign bus.soft_reset_1 = 1'b0;
  assign bus.soft_reset_2 = 1'b0;
`endif
endmodule
